// File: rtl/rggen_bit_field_threshold_counter.sv
// rtl/rggen_bit_field_threshold_counter.sv - up/down event counter with threshold hit, capture and sticky range flags
module rggen_bit_field_threshold_counter #(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] INITIAL_VALUE = {WIDTH{1'b0}},
    parameter int               UP_WIDTH      = 1,
    parameter int               DOWN_WIDTH    = 1,
    parameter int               WRAP_AROUND   = 0,
    parameter int               USE_CLEAR     = 1
) (
    input  logic                                              i_clk,
    input  logic                                              i_rst_n,
    input  logic                                              i_sw_write_valid,
    input  logic                                              i_sw_read_valid,
    input  logic [WIDTH-1:0]                                  i_sw_mask,
    input  logic [WIDTH-1:0]                                  i_sw_write_data,
    output logic [WIDTH-1:0]                                  o_sw_read_data,
    output logic [WIDTH-1:0]                                  o_sw_value,
    input  logic                                              i_clear,
    input  logic                                              i_enable,
    input  logic [((UP_WIDTH > 0) ? UP_WIDTH : 1)-1:0]        i_up,
    input  logic [((DOWN_WIDTH > 0) ? DOWN_WIDTH : 1)-1:0]    i_down,
    input  logic [WIDTH-1:0]                                  i_threshold,
    input  logic                                              i_capture,
    output logic [WIDTH-1:0]                                  o_capture,
    input  logic                                              i_flag_clear,
    output logic [WIDTH-1:0]                                  o_count,
    output logic                                              o_hit,
    output logic                                              o_hit_event,
    output logic                                              o_overflow,
    output logic                                              o_underflow
);

    localparam int UW     = (UP_WIDTH > 0) ? UP_WIDTH : 1;
    localparam int DW     = (DOWN_WIDTH > 0) ? DOWN_WIDTH : 1;
    localparam int MAXW   = (UW > DW) ? UW : DW;
    localparam int STEP_W = $clog2(MAXW + 1) + 1;
    localparam int SUM_W  = ((WIDTH + 2) > (STEP_W + 1)) ? (WIDTH + 2) : (STEP_W + 1);

    logic [WIDTH-1:0]         count_q;
    logic [WIDTH-1:0]         count_d;
    logic [WIDTH-1:0]         capture_q;
    logic                     overflow_q;
    logic                     overflow_d;
    logic                     underflow_q;
    logic                     underflow_d;
    logic                     hit_q;

    logic [UW-1:0]            up_lanes;
    logic [DW-1:0]            down_lanes;
    logic [STEP_W-1:0]        up_total;
    logic [STEP_W-1:0]        down_total;
    logic signed [STEP_W-1:0] step;
    logic signed [SUM_W-1:0]  sum;
    logic                     clear;
    logic                     count_event;
    logic                     sum_over;
    logic                     sum_under;
    logic                     hit;
    logic                     unused_inputs;

    // A disabled direction contributes no lanes, whatever is tied to its port.
    assign up_lanes   = (UP_WIDTH > 0) ? i_up : '0;
    assign down_lanes = (DOWN_WIDTH > 0) ? i_down : '0;
    assign clear      = (USE_CLEAR != 0) && i_clear;

    always_comb begin
        up_total = '0;
        for (int i = 0; i < UW; i++) begin
            up_total = up_total + STEP_W'(up_lanes[i]);
        end
    end

    always_comb begin
        down_total = '0;
        for (int i = 0; i < DW; i++) begin
            down_total = down_total + STEP_W'(down_lanes[i]);
        end
    end

    assign step        = $signed(up_total) - $signed(down_total);
    assign sum         = $signed({{(SUM_W-WIDTH){1'b0}}, count_q})
                       + $signed({{(SUM_W-STEP_W){step[STEP_W-1]}}, step});
    assign sum_under   = sum[SUM_W-1];
    assign sum_over    = !sum[SUM_W-1] && (|sum[SUM_W-2:WIDTH]);
    assign count_event = i_enable && ((|up_lanes) || (|down_lanes));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = INITIAL_VALUE;
        end else if (i_sw_write_valid) begin
            count_d = (count_q & ~i_sw_mask) | (i_sw_write_data & i_sw_mask);
        end else if (count_event) begin
            if (WRAP_AROUND != 0) begin
                count_d = sum[WIDTH-1:0];
            end else if (sum_over) begin
                count_d = '1;
            end else if (sum_under) begin
                count_d = '0;
            end else begin
                count_d = sum[WIDTH-1:0];
            end
        end
    end

    // A flag raised in the same cycle as i_flag_clear stays raised.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (!i_sw_write_valid && count_event && sum_over) begin
                overflow_d = 1'b1;
            end else if (i_flag_clear) begin
                overflow_d = 1'b0;
            end
            if (!i_sw_write_valid && count_event && sum_under) begin
                underflow_d = 1'b1;
            end else if (i_flag_clear) begin
                underflow_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q     <= INITIAL_VALUE;
            capture_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            hit_q       <= hit;
            if (i_capture) begin
                capture_q <= count_q;
            end
        end
    end

    assign hit            = count_q >= i_threshold;
    assign o_hit          = hit;
    assign o_hit_event    = hit && !hit_q;
    assign o_count        = count_q;
    assign o_sw_value     = count_q;
    assign o_sw_read_data = count_q;
    assign o_capture      = capture_q;
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

    // Reads are side-effect free; lanes may be ignored when a direction is disabled.
    assign unused_inputs  = ^{i_sw_read_valid, i_up, i_down, i_clear};

endmodule

// File: tb/tb_rggen_bit_field_threshold_counter.sv
// tb/tb_rggen_bit_field_threshold_counter.sv - table, directed and randomized checks for saturating and wrapping counters
module tb_rggen_bit_field_threshold_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw_wr, sw_rd, clear, enable, cap, fclr;
    logic [3:0] mask, data, thr;
    logic [1:0] up, down;

    logic [3:0] s_rd, s_val, s_cnt, s_cap;
    logic       s_hit, s_ev, s_ovf, s_unf;
    logic [3:0] w_rd, w_val, w_cnt, w_cap;
    logic       w_hit, w_ev, w_ovf, w_unf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rggen_bit_field_threshold_counter #(
        .WIDTH(4), .INITIAL_VALUE(4'h0), .UP_WIDTH(2), .DOWN_WIDTH(2),
        .WRAP_AROUND(0), .USE_CLEAR(1)
    ) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_sw_write_valid(sw_wr), .i_sw_read_valid(sw_rd),
        .i_sw_mask(mask), .i_sw_write_data(data),
        .o_sw_read_data(s_rd), .o_sw_value(s_val),
        .i_clear(clear), .i_enable(enable), .i_up(up), .i_down(down),
        .i_threshold(thr), .i_capture(cap), .o_capture(s_cap),
        .i_flag_clear(fclr), .o_count(s_cnt), .o_hit(s_hit), .o_hit_event(s_ev),
        .o_overflow(s_ovf), .o_underflow(s_unf)
    );

    rggen_bit_field_threshold_counter #(
        .WIDTH(4), .INITIAL_VALUE(4'h0), .UP_WIDTH(2), .DOWN_WIDTH(2),
        .WRAP_AROUND(1), .USE_CLEAR(1)
    ) dut_wrap (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_sw_write_valid(sw_wr), .i_sw_read_valid(sw_rd),
        .i_sw_mask(mask), .i_sw_write_data(data),
        .o_sw_read_data(w_rd), .o_sw_value(w_val),
        .i_clear(clear), .i_enable(enable), .i_up(up), .i_down(down),
        .i_threshold(thr), .i_capture(cap), .o_capture(w_cap),
        .i_flag_clear(fclr), .o_count(w_cnt), .o_hit(w_hit), .o_hit_event(w_ev),
        .o_overflow(w_ovf), .o_underflow(w_unf)
    );

    typedef struct {
        bit       clr, wr, rd, en, fclr;
        bit [3:0] mask, data;
        bit [1:0] up, dn;
        bit [3:0] es;
        bit       ovs, uns;
        bit [3:0] ew;
        bit       ovw, unw, hs, hw;
    } vec_t;

    vec_t tbl[17];

    // Reference state, index 0 = saturating, 1 = wrapping.
    int m_cnt[2], m_cap[2];
    bit m_ovf[2], m_unf[2], m_prev[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sw_wr = 0; sw_rd = 0; clear = 0; enable = 0; cap = 0; fclr = 0;
        mask = 0; data = 0; up = 0; down = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        #2;
        rst_n = 1;
        for (int m = 0; m < 2; m++) begin
            m_cnt[m] = 0; m_cap[m] = 0; m_ovf[m] = 0; m_unf[m] = 0; m_prev[m] = 0;
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            int old, s;
            bit so, su;
            old = m_cnt[m]; so = 0; su = 0;
            if (cap) m_cap[m] = old;
            m_prev[m] = (old >= int'(thr));
            if (clear) begin
                m_cnt[m] = 0; m_ovf[m] = 0; m_unf[m] = 0;
            end else begin
                if (sw_wr) begin
                    m_cnt[m] = (old & ~int'(mask)) | int'(data & mask);
                end else if (enable && (up != 0 || down != 0)) begin
                    s = old + $countones(up) - $countones(down);
                    if (s > 15) begin
                        so = 1; m_cnt[m] = (m == 1) ? s - 16 : 15;
                    end else if (s < 0) begin
                        su = 1; m_cnt[m] = (m == 1) ? s + 16 : 0;
                    end else begin
                        m_cnt[m] = s;
                    end
                end
                m_ovf[m] = so ? 1'b1 : (fclr ? 1'b0 : m_ovf[m]);
                m_unf[m] = su ? 1'b1 : (fclr ? 1'b0 : m_unf[m]);
            end
        end
    endtask

    task automatic check_model(input int cyc);
        logic [3:0] cnt[2], rdd[2], val[2], cp[2];
        logic       hit[2], ev[2], ov[2], un[2];
        bit         eh;
        cnt[0] = s_cnt; rdd[0] = s_rd; val[0] = s_val; cp[0] = s_cap;
        hit[0] = s_hit; ev[0] = s_ev; ov[0] = s_ovf; un[0] = s_unf;
        cnt[1] = w_cnt; rdd[1] = w_rd; val[1] = w_val; cp[1] = w_cap;
        hit[1] = w_hit; ev[1] = w_ev; ov[1] = w_ovf; un[1] = w_unf;
        for (int m = 0; m < 2; m++) begin
            eh = (m_cnt[m] >= int'(thr));
            chk($sformatf("rnd%0d_m%0d_count", cyc, m), 32'(cnt[m]), 32'(m_cnt[m]));
            chk($sformatf("rnd%0d_m%0d_read", cyc, m), 32'(rdd[m]), 32'(m_cnt[m]));
            chk($sformatf("rnd%0d_m%0d_value", cyc, m), 32'(val[m]), 32'(m_cnt[m]));
            chk($sformatf("rnd%0d_m%0d_capture", cyc, m), 32'(cp[m]), 32'(m_cap[m]));
            chk($sformatf("rnd%0d_m%0d_ovf", cyc, m), 32'(ov[m]), 32'(m_ovf[m]));
            chk($sformatf("rnd%0d_m%0d_unf", cyc, m), 32'(un[m]), 32'(m_unf[m]));
            chk($sformatf("rnd%0d_m%0d_hit", cyc, m), 32'(hit[m]), 32'(eh));
            chk($sformatf("rnd%0d_m%0d_event", cyc, m), 32'(ev[m]), 32'(eh && !m_prev[m]));
        end
    endtask

    initial begin
        //          clr wr rd en fc mask  data  up     dn     es    ovs uns ew    ovw unw hs hw
        tbl[0]  = '{0, 1, 0, 0, 0, 4'hF, 4'hE, 2'b00, 2'b00, 4'hE, 0, 0, 4'hE, 0, 0, 1, 1};
        tbl[1]  = '{0, 0, 1, 1, 0, 4'hF, 4'h0, 2'b11, 2'b00, 4'hF, 1, 0, 4'h0, 1, 0, 1, 0};
        tbl[2]  = '{0, 0, 0, 1, 0, 4'h0, 4'h0, 2'b11, 2'b00, 4'hF, 1, 0, 4'h2, 1, 0, 1, 0};
        tbl[3]  = '{0, 0, 0, 0, 1, 4'h0, 4'h0, 2'b00, 2'b00, 4'hF, 0, 0, 4'h2, 0, 0, 1, 0};
        tbl[4]  = '{0, 1, 0, 0, 0, 4'hF, 4'h1, 2'b00, 2'b00, 4'h1, 0, 0, 4'h1, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 1, 0, 4'h0, 4'h0, 2'b00, 2'b11, 4'h0, 0, 1, 4'hF, 0, 1, 0, 1};
        tbl[6]  = '{0, 0, 0, 0, 1, 4'h0, 4'h0, 2'b00, 2'b00, 4'h0, 0, 0, 4'hF, 0, 0, 0, 1};
        tbl[7]  = '{0, 1, 0, 0, 0, 4'hF, 4'h5, 2'b00, 2'b00, 4'h5, 0, 0, 4'h5, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 1, 0, 4'h0, 4'h0, 2'b11, 2'b01, 4'h6, 0, 0, 4'h6, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 4'h0, 4'h0, 2'b11, 2'b01, 4'h6, 0, 0, 4'h6, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 1, 1, 0, 4'h0, 4'h0, 2'b01, 2'b01, 4'h6, 0, 0, 4'h6, 0, 0, 0, 0};
        tbl[11] = '{1, 1, 0, 1, 0, 4'hF, 4'hA, 2'b01, 2'b00, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0};
        tbl[12] = '{0, 1, 0, 1, 0, 4'hF, 4'hA, 2'b01, 2'b00, 4'hA, 0, 0, 4'hA, 0, 0, 1, 1};
        tbl[13] = '{0, 1, 0, 0, 0, 4'h3, 4'h5, 2'b00, 2'b00, 4'h9, 0, 0, 4'h9, 0, 0, 1, 1};
        tbl[14] = '{0, 1, 0, 0, 0, 4'hF, 4'hF, 2'b00, 2'b00, 4'hF, 0, 0, 4'hF, 0, 0, 1, 1};
        tbl[15] = '{0, 0, 0, 1, 1, 4'h0, 4'h0, 2'b01, 2'b00, 4'hF, 1, 0, 4'h0, 1, 0, 1, 0};
        tbl[16] = '{1, 0, 0, 1, 0, 4'h0, 4'h0, 2'b01, 2'b00, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0};

        idle();
        thr   = 4'd8;
        rst_n = 0;
        #12;
        chk("reset_count", 32'(s_cnt), 0);
        chk("reset_capture", 32'(s_cap), 0);
        chk("reset_ovf", 32'(s_ovf), 0);
        chk("reset_unf", 32'(s_unf), 0);
        chk("reset_hit", 32'(s_hit), 0);
        chk("reset_event", 32'(s_ev), 0);
        chk("reset_wrap_count", 32'(w_cnt), 0);
        rst_n = 1;

        for (int i = 0; i < 17; i++) begin
            clear = tbl[i].clr; sw_wr = tbl[i].wr; sw_rd = tbl[i].rd; enable = tbl[i].en;
            fclr = tbl[i].fclr; mask = tbl[i].mask; data = tbl[i].data;
            up = tbl[i].up; down = tbl[i].dn;
            tick();
            chk($sformatf("tbl%0d_sat_count", i), 32'(s_cnt), 32'(tbl[i].es));
            chk($sformatf("tbl%0d_sat_ovf", i), 32'(s_ovf), 32'(tbl[i].ovs));
            chk($sformatf("tbl%0d_sat_unf", i), 32'(s_unf), 32'(tbl[i].uns));
            chk($sformatf("tbl%0d_sat_hit", i), 32'(s_hit), 32'(tbl[i].hs));
            chk($sformatf("tbl%0d_wrap_count", i), 32'(w_cnt), 32'(tbl[i].ew));
            chk($sformatf("tbl%0d_wrap_ovf", i), 32'(w_ovf), 32'(tbl[i].ovw));
            chk($sformatf("tbl%0d_wrap_unf", i), 32'(w_unf), 32'(tbl[i].unw));
            chk($sformatf("tbl%0d_wrap_hit", i), 32'(w_hit), 32'(tbl[i].hw));
        end

        // Threshold crossing produces a single event pulse.
        do_reset();
        thr = 4'd3;
        sw_wr = 1; mask = 4'hF; data = 4'h2;
        tick();
        idle();
        chk("thr_below_hit", 32'(s_hit), 0);
        chk("thr_below_event", 32'(s_ev), 0);
        enable = 1; up = 2'b01;
        tick();
        idle();
        chk("thr_cross_count", 32'(s_cnt), 3);
        chk("thr_cross_hit", 32'(s_hit), 1);
        chk("thr_cross_event", 32'(s_ev), 1);
        tick();
        chk("thr_hold_event", 32'(s_ev), 0);
        chk("thr_hold_hit", 32'(s_hit), 1);
        enable = 1; up = 2'b01;
        tick();
        idle();
        chk("thr_above_count", 32'(s_cnt), 4);
        chk("thr_above_event", 32'(s_ev), 0);

        // Capture sees the pre-update count; async reset mid-cycle clears everything.
        sw_wr = 1; mask = 4'hF; data = 4'h7;
        tick();
        idle();
        cap = 1; enable = 1; up = 2'b01;
        tick();
        idle();
        chk("cap_value", 32'(s_cap), 7);
        chk("cap_count", 32'(s_cnt), 8);
        chk("cap_wrap_value", 32'(w_cap), 7);
        sw_wr = 1; mask = 4'hF; data = 4'hF;
        tick();
        idle();
        enable = 1; up = 2'b01;
        tick();
        idle();
        chk("pre_reset_ovf", 32'(s_ovf), 1);
        #3;
        thr   = 4'd0;
        rst_n = 0;
        #1;
        chk("async_count", 32'(s_cnt), 0);
        chk("async_capture", 32'(s_cap), 0);
        chk("async_ovf", 32'(s_ovf), 0);
        chk("async_wrap_ovf", 32'(w_ovf), 0);
        chk("async_unf", 32'(s_unf), 0);
        chk("async_hit", 32'(s_hit), 1);
        chk("async_event", 32'(s_ev), 1);
        #2;
        rst_n = 1;
        tick();
        chk("post_reset_count", 32'(s_cnt), 0);
        chk("post_reset_event", 32'(s_ev), 0);

        do_reset();
        for (int c = 0; c < 400; c++) begin
            clear  = ($urandom_range(15) == 0);
            sw_wr  = ($urandom_range(7) == 0);
            sw_rd  = $urandom_range(1);
            enable = ($urandom_range(3) != 0);
            fclr   = ($urandom_range(7) == 0);
            cap    = ($urandom_range(3) == 0);
            mask   = 4'($urandom_range(15));
            data   = 4'($urandom_range(15));
            up     = 2'($urandom_range(3));
            down   = 2'($urandom_range(3));
            thr    = 4'($urandom_range(15));
            model_edge();
            tick();
            check_model(c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
